// File: rtl/spi_master_engine.sv
// spi_master_engine
//   SPI master core: a small TX FIFO feeds a shift engine that serialises words on
//   spi_sck/spi_mosi, captures spi_miso into rx_data and drives one active-low chip select.
//   Handles all four CPOL/CPHA modes, MSB/LSB-first order, a programmable SCK divider
//   and optional CS hold across back-to-back words.
// Ports
//   clk, rstn                 system clock, asynchronous active-low reset
//   cfg_cpol/cpha/lsb         SPI mode and bit order (latched when a word is popped)
//   cfg_div                   SCK half-period = cfg_div+1 clk cycles
//   cfg_cs_sel, cfg_cs_hold   chip select index, keep CS low between queued words
//   tx_valid/tx_ready/tx_data TX FIFO push interface
//   rx_valid, rx_data         one-cycle pulse with the received word, data held afterwards
//   busy                      engine active or FIFO non-empty
//   spi_sck/mosi/miso/cs_n    SPI pad signals
module spi_master_engine #(
    parameter int DATA_W     = 8,
    parameter int NUM_CS     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 16
) (
    input  logic                                           clk,
    input  logic                                           rstn,
    input  logic                                           cfg_cpol,
    input  logic                                           cfg_cpha,
    input  logic                                           cfg_lsb,
    input  logic [DIV_W-1:0]                               cfg_div,
    input  logic [((NUM_CS > 1) ? $clog2(NUM_CS) : 1)-1:0] cfg_cs_sel,
    input  logic                                           cfg_cs_hold,
    input  logic                                           tx_valid,
    output logic                                           tx_ready,
    input  logic [DATA_W-1:0]                              tx_data,
    output logic                                           rx_valid,
    output logic [DATA_W-1:0]                              rx_data,
    output logic                                           busy,
    output logic                                           spi_sck,
    output logic                                           spi_mosi,
    input  logic                                           spi_miso,
    output logic [NUM_CS-1:0]                              spi_cs_n
);

    localparam int CSW = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int EW  = $clog2(2 * DATA_W);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD, S_GAP} state_t;

    function automatic logic f_bit(input logic [DATA_W-1:0] d, input logic lsb);
        return lsb ? d[0] : d[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] f_shift(input logic [DATA_W-1:0] d, input logic lsb);
        return lsb ? (d >> 1) : (d << 1);
    endfunction

    // ---------------- TX FIFO ----------------
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wptr, r_rptr;
    logic [AW:0]       r_count;
    logic              r_rdy;
    logic              w_push, w_pop, w_empty, w_full;
    logic [DATA_W-1:0] w_head;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == (AW+1)'(FIFO_DEPTH));
    assign tx_ready = r_rdy & ~w_full;
    assign w_push   = tx_valid & tx_ready;
    assign w_head   = r_mem[r_rptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_rdy   <= 1'b0;
        end else begin
            r_rdy <= 1'b1;
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= tx_data;
    end

    // ---------------- Engine state ----------------
    state_t            r_state, w_state_nxt;
    logic              r_cpol, r_cpha, r_lsb, r_cs_hold;
    logic [DIV_W-1:0]  r_div, r_cnt;
    logic [CSW-1:0]    r_cs_sel;
    logic [EW-1:0]     r_edge;
    logic              r_sck, r_mosi, r_rx_valid;
    logic [NUM_CS-1:0] r_cs_n;
    logic [DATA_W-1:0] r_tx, r_rx_sh, r_rx_data;
    logic              w_tick, w_last, w_cont, w_sample;
    logic [DATA_W-1:0] w_rx_next;

    assign w_tick    = (r_state != S_IDLE) && (r_cnt == '0);
    assign w_last    = (r_edge == LAST_EDGE);
    assign w_cont    = r_cs_hold && !w_empty && (cfg_cs_sel == r_cs_sel);
    // Even edge indices are leading edges; CPHA=0 samples on them, CPHA=1 on odd ones.
    assign w_sample  = (r_edge[0] == r_cpha);
    assign w_rx_next = r_lsb ? {spi_miso, r_rx_sh[DATA_W-1:1]} : {r_rx_sh[DATA_W-2:0], spi_miso};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            S_IDLE:  if (!w_empty) begin
                         w_pop       = 1'b1;
                         w_state_nxt = S_SETUP;
                     end
            S_SETUP: if (w_tick) w_state_nxt = S_XFER;
            S_XFER:  if (w_tick && w_last) w_state_nxt = S_HOLD;
            S_HOLD:  if (w_tick) begin
                         if (w_cont) begin
                             w_pop       = 1'b1;
                             w_state_nxt = S_XFER;
                         end else begin
                             w_state_nxt = S_GAP;
                         end
                     end
            S_GAP:   if (w_tick) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_lsb      <= 1'b0;
            r_cs_hold  <= 1'b0;
            r_div      <= '0;
            r_cs_sel   <= '0;
            r_cnt      <= '0;
            r_edge     <= '0;
            r_sck      <= 1'b0;
            r_mosi     <= 1'b0;
            r_cs_n     <= '1;
            r_tx       <= '0;
            r_rx_sh    <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (w_pop) begin
                r_cpol    <= cfg_cpol;
                r_cpha    <= cfg_cpha;
                r_lsb     <= cfg_lsb;
                r_cs_hold <= cfg_cs_hold;
                r_div     <= cfg_div;
                r_cs_sel  <= cfg_cs_sel;
                r_cnt     <= cfg_div;
                r_edge    <= '0;
                r_sck     <= cfg_cpol;
                r_cs_n    <= ~(NUM_CS'(1) << cfg_cs_sel);
                // CPHA=0 presents the first bit before any SCK edge.
                if (!cfg_cpha) begin
                    r_mosi <= f_bit(w_head, cfg_lsb);
                    r_tx   <= f_shift(w_head, cfg_lsb);
                end else begin
                    r_tx   <= w_head;
                end
            end else begin
                if (r_state != S_IDLE) r_cnt <= w_tick ? r_div : r_cnt - DIV_W'(1);
                case (r_state)
                    S_IDLE: r_sck <= cfg_cpol;
                    S_XFER: if (w_tick) begin
                        r_sck  <= ~r_sck;
                        r_edge <= r_edge + EW'(1);
                        if (w_sample) begin
                            r_rx_sh <= w_rx_next;
                        end else begin
                            r_mosi <= f_bit(r_tx, r_lsb);
                            r_tx   <= f_shift(r_tx, r_lsb);
                        end
                        if (w_last) begin
                            r_rx_valid <= 1'b1;
                            r_rx_data  <= w_sample ? w_rx_next : r_rx_sh;
                        end
                    end
                    S_HOLD: begin
                        r_sck <= r_cpol;
                        if (w_tick) r_cs_n <= '1;
                    end
                    S_GAP:  r_sck <= r_cpol;
                    default: ;
                endcase
            end
        end
    end

    assign rx_valid = r_rx_valid;
    assign rx_data  = r_rx_data;
    assign busy     = (r_state != S_IDLE) || !w_empty;
    assign spi_sck  = r_sck;
    assign spi_mosi = r_mosi;
    assign spi_cs_n = r_cs_n;

endmodule
